// File: rtl/mlp_load_sequencer.sv
// Streams int16 elements into paired 32-bit load beats for the MLP accelerator:
// layer 0 interleaves input rows with weight rows, then the later layers are weights only.
module mlp_load_sequencer #(
  parameter int NUM_LAYERS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        load_en_o,
  output logic [31:0] load_payload_o,
  output logic        load_type_o,
  output logic [3:0]  input_load_number_o,
  output logic [2:0]  layer_number_o,
  output logic [2:0]  weight_number_o
);

  // state | meaning
  // IDLE  | waiting for start
  // LD_IN | streaming the 16 input elements of the current layer-0 row
  // LD_W  | streaming the 16 weight elements of the current row
  // DONE  | final beat on the bus, then one cycle with done=1
  typedef enum logic [1:0] {IDLE, LD_IN, LD_W, DONE} state_t;

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t      state;
  logic [2:0]  layer;
  logic [3:0]  row;
  logic [2:0]  col;
  logic        half;
  logic [15:0] hold;
  logic        hs;

  assign s_ready = (state == LD_IN) || (state == LD_W);
  assign busy    = s_ready;
  assign hs      = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      layer               <= '0;
      row                 <= '0;
      col                 <= '0;
      half                <= 1'b0;
      hold                <= '0;
      done                <= 1'b0;
      load_en_o           <= 1'b0;
      load_payload_o      <= '0;
      load_type_o         <= 1'b0;
      input_load_number_o <= '0;
      layer_number_o      <= '0;
      weight_number_o     <= '0;
    end else begin
      load_en_o <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LD_IN;
            layer <= '0;
            row   <= '0;
            col   <= '0;
            half  <= 1'b0;
          end
        end
        LD_IN, LD_W: begin
          if (hs) begin
            if (!half) begin
              hold <= s_data;
              half <= 1'b1;
            end else begin
              half                <= 1'b0;
              load_en_o           <= 1'b1;
              load_payload_o      <= {s_data, hold};
              load_type_o         <= (state == LD_IN);
              input_load_number_o <= row;
              layer_number_o      <= layer;
              weight_number_o     <= col;
              col                 <= col + 3'd1;
              // col wraps to 0 on its own; only row/layer/state need attention at the row end
              if (col == 3'd7) begin
                if (state == LD_IN) begin
                  state <= LD_W;
                end else if (layer == 3'd0) begin
                  if (row != 4'd15) begin
                    row   <= row + 4'd1;
                    state <= LD_IN;
                  end else begin
                    row   <= '0;
                    layer <= 3'd1;
                  end
                end else if (row != 4'd15) begin
                  row <= row + 4'd1;
                end else if (layer != LAST_LAYER) begin
                  row   <= '0;
                  layer <= layer + 3'd1;
                end else begin
                  state <= DONE;
                end
              end
            end
          end
        end
        DONE: begin
          // first DONE cycle carries the final beat; the second raises done
          if (!done) done <= 1'b1;
          else       state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
